mac_frame_scheduler: RTL
========================

# mac_frame_scheduler

Sequences the MAC frame generator for several traffic requesters. Arbitrates frame requests round-robin, latches the winner's descriptor, and drives the generator's start and descriptor inputs. It then slices the generator's full-frame register into 64-bit beats under a valid/ready handshake and enforces an inter-packet gap before the next frame. It sits between the traffic sources and the MII/PCS-side consumer.

## Interface
- N_REQ, 4, number of requesters (2..8)
- PAYLOAD_MAX_SIZE, 1500, must equal the generator's value
- SETTLE_CYCLES, 2, cycles `o_gen_start` is held before the first beat (≥1)
- IPG_CYCLES, 12, idle cycles after the last beat (0 allowed)
- REG_W, PAYLOAD_MAX_SIZE*8+208, generator register width (derived)

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  N_REQ  per-requester frame request, level
- i_dest_address  in  [N_REQ] x 48  per-requester destination MAC
- i_src_address  in  [N_REQ] x 48  per-requester source MAC
- i_payload_length  in  [N_REQ] x 16  per-requester payload bytes
- i_mode  in  [N_REQ] x 8  per-requester interrupt code (1 = FIXED_PAYLOAD, 2 = NO_PADDING)
- o_grant  out  N_REQ  one-hot, 1-cycle pulse when a descriptor is latched
- o_gen_start  out  1  generator start
- o_gen_dest, o_gen_src  out  48 each  latched descriptor
- o_gen_length  out  16  latched, clamped length
- o_gen_interrupt  out  8  latched mode
- i_gen_register  in  REG_W  generator full frame, byte 0 = bits [7:0]
- o_data  out  64  beat data
- o_keep  out  8  byte-lane valid; bit k covers o_data[8k+7:8k]
- o_valid  out  1  beat valid
- o_last  out  1  final beat of frame
- i_ready  in  1  consumer accepts beat
- o_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, LOAD, STREAM, IPG.
- IDLE, any i_req set:
  - grant the first set request at or after the RR pointer;
  - latch that requester's descriptor and pulse o_grant;
  - length is clamped to PAYLOAD_MAX_SIZE;
  - pointer ← winner+1 mod N_REQ;
  - go to LOAD.
- LOAD: o_gen_start=1. Count SETTLE_CYCLES, then go to STREAM with beat index 0.
- STREAM:
  - o_gen_start stays 1;
  - o_data = i_gen_register[64·beat +: 64];
  - the beat advances on o_valid && i_ready;
  - after the last beat is accepted, go to IPG, or to IDLE if IPG_CYCLES=0.
- IPG: o_gen_start=0. Count IPG_CYCLES, then go to IDLE.
- Frame bytes: TOTAL = 8 + 14 + P + 4.
  - P = L if mode = NO_PADDING;
  - otherwise P = max(L, 46).
- BEATS = ceil(TOTAL/8).
- Last beat: o_last=1, o_keep = (1<<(TOTAL mod 8))−1, or 0xFF when the remainder is 0. All other beats have o_keep=0xFF.
- Arithmetic is 16-bit, unsigned. Beat index is 16 bits.
- Dropping i_req after the grant has no effect; the descriptor is already latched.
- Requests arriving during LOAD, STREAM or IPG wait.
- Reset mid-frame aborts the frame. No partial-frame recovery.

## Timing
- Reset values:
  - all outputs 0, including o_gen_* and o_keep;
  - state IDLE, RR pointer 0.
- Grant at cycle T (registered o_grant visible at T+1).
- LOAD occupies T+1..T+SETTLE_CYCLES. The first o_valid is at T+SETTLE_CYCLES+1.
- With i_ready held high, a frame streams in BEATS consecutive cycles.
- The next grant comes at the earliest IPG_CYCLES cycles after the last-beat acceptance.
- While i_ready=0, o_data, o_keep and o_last are held stable and o_valid stays 1.
- o_valid is never deasserted mid-frame.
- Simultaneous requests resolve in one cycle by RR order.

## Configuration
- MAC_SCHED_STATS_EN:
  - When defined, adds output o_frame_count (32 bits, reset 0). It increments on each last-beat acceptance and wraps at 2^32−1 → 0.
  - It also adds o_stall_count (32 bits). This counts STREAM cycles with o_valid && !i_ready and saturates at 2^32−1.
  - Without the macro, these ports and counters do not exist.

## Structure
- Shared package mac_pkg holds:
  - state enum;
  - mode constants FIXED_PAYLOAD=8'd1 and NO_PADDING=8'd2;
  - PREAMBLE_BYTES=8, HEADER_BYTES=14, MIN_PAYLOAD_SIZE=46, CRC_BYTES=4.
- Sub-module rr_arbiter (parameter N):
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and valid.
  - The scheduler owns the pointer update.

## Test plan
- req0 only, L=46, mode 0, SETTLE=2, IPG=12 → 9 beats, beat0 = 64'hD555555555555555, last keep 0xFF, o_last on beat 9, next grant ≥12 cycles later.
- req0, L=50 → TOTAL 76, 10 beats, last keep 0x0F.
- req0 and req1 held high continuously → grants 0,1,0,1; pointer wraps correctly with N_REQ=4 when req3 and req0 are active.
- i_ready low for 3 cycles at beat 4 → o_data and o_keep unchanged, o_valid=1; 9 beats total; stall count +3 with MAC_SCHED_STATS_EN.
- req2, mode NO_PADDING, L=8 → TOTAL 34, 5 beats, last keep 0x03; L=2000 → o_gen_length=1500.
- i_rst_n low mid-STREAM → all outputs 0 immediately; after release, req1 and req0 both high → req0 granted first.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and frame constants for the MAC frame scheduler.
// Optional statistics are enabled with MAC_SCHED_STATS_EN.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    IPG
  } state_e;

  localparam logic [7:0] FIXED_PAYLOAD = 8'd1;
  localparam logic [7:0] NO_PADDING    = 8'd2;

  localparam int PREAMBLE_BYTES   = 8;
  localparam int HEADER_BYTES     = 14;
  localparam int MIN_PAYLOAD_SIZE = 46;
  localparam int CRC_BYTES        = 4;

  // Bytes on the wire for a (clamped) payload length and mode.
  function automatic logic [15:0] frame_bytes(
    input logic [15:0] len,
    input logic [7:0]  mode
  );
    logic [15:0] p;
    if (mode == NO_PADDING || len >= 16'(MIN_PAYLOAD_SIZE))
      p = len;
    else
      p = 16'(MIN_PAYLOAD_SIZE);
    return p + 16'(PREAMBLE_BYTES + HEADER_BYTES + CRC_BYTES);
  endfunction

endpackage

// File: rtl/mac_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer.
// The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] j;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr_i) + i) % N);
      if (en_i && !valid_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_frame_scheduler.sv
// Arbitrates requesters, drives the frame generator, streams 64-bit beats.
// Define MAC_SCHED_STATS_EN to add frame and stall counters.
module mac_frame_scheduler
  import mac_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int SETTLE_CYCLES    = 2,
  parameter int IPG_CYCLES       = 12,
  parameter int REG_W            = PAYLOAD_MAX_SIZE*8+208
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [N_REQ-1:0]  i_req,
  input  logic [47:0]       i_dest_address   [N_REQ],
  input  logic [47:0]       i_src_address    [N_REQ],
  input  logic [15:0]       i_payload_length [N_REQ],
  input  logic [7:0]        i_mode           [N_REQ],
  output logic [N_REQ-1:0]  o_grant,
  output logic              o_gen_start,
  output logic [47:0]       o_gen_dest,
  output logic [47:0]       o_gen_src,
  output logic [15:0]       o_gen_length,
  output logic [7:0]        o_gen_interrupt,
  input  logic [REG_W-1:0]  i_gen_register,
  output logic [63:0]       o_data,
  output logic [7:0]        o_keep,
  output logic              o_valid,
  output logic              o_last,
`ifdef MAC_SCHED_STATS_EN
  output logic [31:0]       o_frame_count,
  output logic [31:0]       o_stall_count,
`endif
  output logic              o_busy,
  input  logic              i_ready
);

  localparam int PW = $clog2(N_REQ);
  localparam int XW = REG_W + 64;
  localparam int OW = $clog2(XW);

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        beat_q, beat_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [47:0]        dest_q, dest_d;
  logic [47:0]        src_q, src_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         mode_q, mode_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_valid;
  logic [PW-1:0]      win;
  logic [15:0]        sel_len;
  logic [15:0]        total;
  logic [15:0]        beats;
  logic               last;
  logic               streaming;
  logic [7:0]         keep_last;
  logic [XW-1:0]      reg_ext;
  logic [OW-1:0]      off;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_gnt[i]) win = PW'(i);
  end

  assign sel_len = i_payload_length[win];

  assign total     = frame_bytes(len_q, mode_q);
  assign beats     = (total + 16'd7) >> 3;
  assign last      = (beat_q == beats - 16'd1);
  assign streaming = (state_q == STREAM);
  assign keep_last = (total[2:0] == 3'd0) ? 8'hFF
                   : (8'd1 << total[2:0]) - 8'd1;

  // Zero pad so the final partial beat never slices past the register.
  assign reg_ext = {64'd0, i_gen_register};
  assign off     = OW'({beat_q, 6'd0});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    dest_d  = dest_q;
    src_d   = src_q;
    len_d   = len_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          dest_d  = i_dest_address[win];
          src_d   = i_src_address[win];
          mode_d  = i_mode[win];
          len_d   = (sel_len > 16'(PAYLOAD_MAX_SIZE))
                  ? 16'(PAYLOAD_MAX_SIZE) : sel_len;
          ptr_d   = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == 16'(SETTLE_CYCLES-1)) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (last) begin
            beat_d  = '0;
            cnt_d   = '0;
            state_d = (IPG_CYCLES == 0) ? IDLE : IPG;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      IPG: begin
        if (cnt_q == 16'(IPG_CYCLES-1))
          state_d = IDLE;
        else
          cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

  assign o_grant         = grant_q;
  assign o_gen_dest      = dest_q;
  assign o_gen_src       = src_q;
  assign o_gen_length    = len_q;
  assign o_gen_interrupt = mode_q;
  assign o_gen_start     = (state_q == LOAD) || streaming;
  assign o_busy          = (state_q != IDLE);
  assign o_valid         = streaming;
  assign o_last          = streaming && last;
  assign o_keep          = !streaming ? 8'h00 : (last ? keep_last : 8'hFF);
  assign o_data          = streaming ? reg_ext[off +: 64] : 64'd0;

`ifdef MAC_SCHED_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      if (o_valid && i_ready && last)
        frames_q <= frames_q + 32'd1;
      if (o_valid && !i_ready && stalls_q != '1)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign o_frame_count = frames_q;
  assign o_stall_count = stalls_q;
`endif

endmodule
